// File: rtl/niu_sii_dma_req_tx.sv
// NIU->SII DMA request transmitter: header/payload sequencing, OQ/BQ credits, parity.
// Optional NIU_SII_PAR_INJ_EN: inj_par_err flips niu_sii_parity[0] on the beat it is registered with.
module niu_sii_dma_req_tx #(
   parameter int OQ_CREDITS = 4,
   parameter int BQ_CREDITS = 4
) (
   input  logic         iol2clk,
   input  logic         iol2_rst,
   input  logic         req_vld,
   output logic         req_rdy,
   input  logic         req_wr,
   input  logic         req_sz16,
   input  logic         req_byp,
   input  logic [15:0]  req_tag,
   input  logic [39:0]  req_pa,
   input  logic [127:0] wr_data,
   input  logic [15:0]  wr_be,
   output logic         wr_data_rd,
   output logic         niu_sii_hdr_vld,
   output logic         niu_sii_reqbypass,
   output logic         niu_sii_datareq,
   output logic         niu_sii_datareq16,
   output logic [127:0] niu_sii_data,
   output logic [7:0]   niu_sii_parity,
   output logic [15:0]  niu_sii_be,
   input  logic         sii_niu_oqdq,
   input  logic         sii_niu_bqdq,
   output logic         cred_err,
   input  logic         inj_par_err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HDR  = 2'd1;
   localparam logic [1:0] ST_PAY  = 2'd2;

   localparam logic [3:0] OQ_MAX = 4'(OQ_CREDITS);
   localparam logic [3:0] BQ_MAX = 4'(BQ_CREDITS);

   logic [1:0]   state_reg, state_next;
   logic [2:0]   beat_cnt_reg, beat_cnt_next;
   logic         cur_wr_reg, cur_sz16_reg;
   logic [3:0]   oq_cred_reg, oq_cred_next;
   logic [3:0]   bq_cred_reg, bq_cred_next;
   logic         cred_err_reg, cred_err_next;

   logic         hdr_vld_reg, reqbypass_reg, datareq_reg, datareq16_reg;
   logic [127:0] data_reg, data_next;
   logic [15:0]  be_reg, be_next;
   logic [7:0]   parity_reg, parity_next, parity_calc;

   logic         last_beat, cred_ok, state_ok, accept, pop;
   logic         oq_take, bq_take;

   // beat_cnt_reg counts payload beats still to be shown, including the current one
   assign last_beat = (beat_cnt_reg == 3'd1);
   assign cred_ok   = req_byp ? (bq_cred_reg != 4'd0) : (oq_cred_reg != 4'd0);
   assign state_ok  = (state_reg == ST_IDLE)
                    | ((state_reg == ST_HDR) & ~cur_wr_reg)
                    | ((state_reg == ST_PAY) & last_beat);
   assign accept    = req_vld & cred_ok & state_ok & ~iol2_rst;

   // A beat is popped whenever another payload beat still has to be registered
   assign pop = ~iol2_rst & (((state_reg == ST_HDR) & cur_wr_reg)
                           | ((state_reg == ST_PAY) & ~last_beat));

   assign req_rdy    = accept;
   assign wr_data_rd = pop;

   always_comb begin
      state_next    = ST_IDLE;
      beat_cnt_next = beat_cnt_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept) state_next = ST_HDR;
         end
         ST_HDR: begin
            if (cur_wr_reg) begin
               state_next    = ST_PAY;
               beat_cnt_next = cur_sz16_reg ? 3'd1 : 3'd4;
            end else if (accept) begin
               state_next = ST_HDR;
            end
         end
         ST_PAY: begin
            if (last_beat) begin
               state_next    = accept ? ST_HDR : ST_IDLE;
               beat_cnt_next = 3'd0;
            end else begin
               state_next    = ST_PAY;
               beat_cnt_next = beat_cnt_reg - 3'd1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Accept and pop are mutually exclusive by construction of state_ok and pop
   always_comb begin
      data_next = '0;
      be_next   = '0;
      if (accept) begin
         data_next = {48'd0, req_tag, 24'd0, req_pa};
      end else if (pop) begin
         data_next = wr_data;
         be_next   = wr_be;
      end
   end

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_par
         assign parity_calc[gi] = ^data_next[16*gi +: 16];
      end
   endgenerate

`ifdef NIU_SII_PAR_INJ_EN
   assign parity_next = parity_calc ^ {7'd0, inj_par_err & (accept | pop)};
`else
   logic par_inj_unused;
   assign par_inj_unused = inj_par_err;
   assign parity_next    = parity_calc;
`endif

   assign oq_take = accept & ~req_byp;
   assign bq_take = accept & req_byp;

   always_comb begin
      oq_cred_next = oq_cred_reg;
      if (oq_take & ~sii_niu_oqdq)
         oq_cred_next = oq_cred_reg - 4'd1;
      else if (~oq_take & sii_niu_oqdq & (oq_cred_reg != OQ_MAX))
         oq_cred_next = oq_cred_reg + 4'd1;
   end

   always_comb begin
      bq_cred_next = bq_cred_reg;
      if (bq_take & ~sii_niu_bqdq)
         bq_cred_next = bq_cred_reg - 4'd1;
      else if (~bq_take & sii_niu_bqdq & (bq_cred_reg != BQ_MAX))
         bq_cred_next = bq_cred_reg + 4'd1;
   end

   // A return with the counter already full means SII returned a credit it never had
   assign cred_err_next = cred_err_reg
                        | (sii_niu_oqdq & (oq_cred_reg == OQ_MAX))
                        | (sii_niu_bqdq & (bq_cred_reg == BQ_MAX));

   always_ff @(posedge iol2clk) begin
      if (iol2_rst) begin
         state_reg     <= ST_IDLE;
         beat_cnt_reg  <= 3'd0;
         cur_wr_reg    <= 1'b0;
         cur_sz16_reg  <= 1'b0;
         oq_cred_reg   <= OQ_MAX;
         bq_cred_reg   <= BQ_MAX;
         cred_err_reg  <= 1'b0;
         hdr_vld_reg   <= 1'b0;
         reqbypass_reg <= 1'b0;
         datareq_reg   <= 1'b0;
         datareq16_reg <= 1'b0;
         data_reg      <= '0;
         be_reg        <= '0;
         parity_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         beat_cnt_reg  <= beat_cnt_next;
         if (accept) begin
            cur_wr_reg   <= req_wr;
            cur_sz16_reg <= req_wr & req_sz16;
         end
         oq_cred_reg   <= oq_cred_next;
         bq_cred_reg   <= bq_cred_next;
         cred_err_reg  <= cred_err_next;
         hdr_vld_reg   <= accept;
         reqbypass_reg <= accept & req_byp;
         datareq_reg   <= accept & req_wr;
         datareq16_reg <= accept & req_wr & req_sz16;
         data_reg      <= data_next;
         be_reg        <= be_next;
         parity_reg    <= parity_next;
      end
   end

   assign niu_sii_hdr_vld   = hdr_vld_reg;
   assign niu_sii_reqbypass = reqbypass_reg;
   assign niu_sii_datareq   = datareq_reg;
   assign niu_sii_datareq16 = datareq16_reg;
   assign niu_sii_data      = data_reg;
   assign niu_sii_be        = be_reg;
   assign niu_sii_parity    = parity_reg;
   assign cred_err          = cred_err_reg;

endmodule

// File: tb/tb_niu_sii_dma_req_tx.sv
// Table-driven bench for niu_sii_dma_req_tx plus directed reset and parity-inject sequences.
module tb_niu_sii_dma_req_tx;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_vld, req_rdy, req_wr, req_sz16, req_byp;
   logic [15:0]  req_tag;
   logic [39:0]  req_pa;
   logic [127:0] wr_data;
   logic [15:0]  wr_be;
   logic         wr_data_rd;
   logic         hdr_vld, reqbypass, datareq, datareq16;
   logic [127:0] sii_data;
   logic [7:0]   sii_parity;
   logic [15:0]  sii_be;
   logic         oqdq, bqdq, cred_err, inj;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   niu_sii_dma_req_tx #(.OQ_CREDITS(4), .BQ_CREDITS(4)) dut (
      .iol2clk(clk), .iol2_rst(rst),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_sz16(req_sz16),
      .req_byp(req_byp), .req_tag(req_tag), .req_pa(req_pa),
      .wr_data(wr_data), .wr_be(wr_be), .wr_data_rd(wr_data_rd),
      .niu_sii_hdr_vld(hdr_vld), .niu_sii_reqbypass(reqbypass),
      .niu_sii_datareq(datareq), .niu_sii_datareq16(datareq16),
      .niu_sii_data(sii_data), .niu_sii_parity(sii_parity), .niu_sii_be(sii_be),
      .sii_niu_oqdq(oqdq), .sii_niu_bqdq(bqdq), .cred_err(cred_err),
      .inj_par_err(inj)
   );

   typedef struct {
      logic         vld, wr, sz16, byp, oqdq, bqdq;
      logic [15:0]  tag;
      logic [39:0]  pa;
      logic [127:0] wd;
      logic [15:0]  wbe;
      logic         e_rdy, e_rd, e_hdr, e_byp, e_dreq, e_dreq16;
      logic [127:0] e_data;
      logic [15:0]  e_be;
      logic [3:0]   e_oq, e_bq;
      logic         e_err;
   } vec_t;

   vec_t tv[$];

   function automatic logic [127:0] hdr(input logic [15:0] t, input logic [39:0] a);
      return {48'd0, t, 24'd0, a};
   endfunction

   function automatic logic [127:0] dbeat(input int k);
      logic [7:0] kk;
      kk = k[7:0];
      return {4{24'hC0FFEE, kk}};
   endfunction

   function automatic logic [7:0] par(input logic [127:0] d);
      logic [7:0] p;
      for (int i = 0; i < 8; i++) p[i] = ^d[16*i +: 16];
      return p;
   endfunction

   task automatic add(input logic vld, wr, sz16, byp, dq_o, dq_b,
                      input logic [15:0] tag, input logic [39:0] pa,
                      input logic [127:0] wd, input logic [15:0] wbe,
                      input logic e_rdy, e_rd, e_hdr, e_byp, e_dreq, e_dreq16,
                      input logic [127:0] e_data, input logic [15:0] e_be,
                      input logic [3:0] e_oq, e_bq, input logic e_err);
      vec_t v;
      v.vld = vld; v.wr = wr; v.sz16 = sz16; v.byp = byp; v.oqdq = dq_o; v.bqdq = dq_b;
      v.tag = tag; v.pa = pa; v.wd = wd; v.wbe = wbe;
      v.e_rdy = e_rdy; v.e_rd = e_rd; v.e_hdr = e_hdr; v.e_byp = e_byp;
      v.e_dreq = e_dreq; v.e_dreq16 = e_dreq16; v.e_data = e_data; v.e_be = e_be;
      v.e_oq = e_oq; v.e_bq = e_bq; v.e_err = e_err;
      tv.push_back(v);
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clr_in();
      req_vld = 0; req_wr = 0; req_sz16 = 0; req_byp = 0; req_tag = '0; req_pa = '0;
      wr_data = '0; wr_be = '0; oqdq = 0; bqdq = 0; inj = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [39:0] PA_A = 40'hF0_0000_0000;

   initial begin
      rst = 1'b1;
      clr_in();

      // single ordered read
      add(1,0,0,0,0,0, 16'h00A5, 40'h12_3456_7880, 0, 0,        1,0,0,0,0,0, 0, 0, 4,4,0);
      add(0,0,0,0,0,0, 0, 0, 0, 0,   0,0,1,0,0,0, hdr(16'h00A5, 40'h12_3456_7880), 0, 3,4,0);
      add(0,0,0,0,0,0, 0, 0, 0, 0,                              0,0,0,0,0,0, 0, 0, 3,4,0);
      // 64B bypass write
      add(1,1,0,1,0,0, 16'h1111, 40'hAA_0000_0040, 0, 0,        1,0,0,0,0,0, 0, 0, 3,4,0);
      add(0,0,0,0,0,0, 0, 0, dbeat(0), 16'hFFFF, 0,1,1,1,1,0, hdr(16'h1111, 40'hAA_0000_0040), 0, 3,3,0);
      add(0,0,0,0,0,0, 0, 0, dbeat(1), 16'hFFFF, 0,1,0,0,0,0, dbeat(0), 16'hFFFF, 3,3,0);
      add(0,0,0,0,0,0, 0, 0, dbeat(2), 16'hFFFF, 0,1,0,0,0,0, dbeat(1), 16'hFFFF, 3,3,0);
      add(0,0,0,0,0,0, 0, 0, dbeat(3), 16'hFFFF, 0,1,0,0,0,0, dbeat(2), 16'hFFFF, 3,3,0);
      add(0,0,0,0,0,0, 0, 0, 0, 0,                0,0,0,0,0,0, dbeat(3), 16'hFFFF, 3,3,0);
      add(0,0,0,0,0,0, 0, 0, 0, 0,                              0,0,0,0,0,0, 0, 0, 3,3,0);
      // 16B write with a read pending behind it
      add(1,1,1,0,0,0, 16'h2222, 40'h55_1234_5670, 0, 0,        1,0,0,0,0,0, 0, 0, 3,3,0);
      add(1,0,0,0,0,0, 16'h3333, 40'h01_0000_0100, dbeat(4), 16'h00FF,
          0,1,1,0,1,1, hdr(16'h2222, 40'h55_1234_5670), 0, 2,3,0);
      add(1,0,0,0,0,0, 16'h3333, 40'h01_0000_0100, 0, 0,        1,0,0,0,0,0, dbeat(4), 16'h00FF, 2,3,0);
      add(0,0,0,0,0,0, 0, 0, 0, 0,   0,0,1,0,0,0, hdr(16'h3333, 40'h01_0000_0100), 0, 1,3,0);
      // refill credits
      add(0,0,0,0,1,1, 0, 0, 0, 0,                              0,0,0,0,0,0, 0, 0, 1,3,0);
      add(0,0,0,0,1,0, 0, 0, 0, 0,                              0,0,0,0,0,0, 0, 0, 2,4,0);
      add(0,0,0,0,1,0, 0, 0, 0, 0,                              0,0,0,0,0,0, 0, 0, 3,4,0);
      // five ordered reads against four credits
      add(1,0,0,0,0,0, 16'hA000, PA_A + 40'd0, 0, 0,            1,0,0,0,0,0, 0, 0, 4,4,0);
      add(1,0,0,0,0,0, 16'hA001, PA_A + 40'd1, 0, 0,  1,0,1,0,0,0, hdr(16'hA000, PA_A + 40'd0), 0, 3,4,0);
      add(1,0,0,0,0,0, 16'hA002, PA_A + 40'd2, 0, 0,  1,0,1,0,0,0, hdr(16'hA001, PA_A + 40'd1), 0, 2,4,0);
      add(1,0,0,0,0,0, 16'hA003, PA_A + 40'd3, 0, 0,  1,0,1,0,0,0, hdr(16'hA002, PA_A + 40'd2), 0, 1,4,0);
      add(1,0,0,0,0,0, 16'hA004, PA_A + 40'd4, 0, 0,  0,0,1,0,0,0, hdr(16'hA003, PA_A + 40'd3), 0, 0,4,0);
      add(1,0,0,0,0,0, 16'hA004, PA_A + 40'd4, 0, 0,            0,0,0,0,0,0, 0, 0, 0,4,0);
      add(1,0,0,0,1,0, 16'hA004, PA_A + 40'd4, 0, 0,            0,0,0,0,0,0, 0, 0, 0,4,0);
      add(1,0,0,0,0,0, 16'hA004, PA_A + 40'd4, 0, 0,            1,0,0,0,0,0, 0, 0, 1,4,0);
      add(0,0,0,0,0,0, 0, 0, 0, 0,   0,0,1,0,0,0, hdr(16'hA004, PA_A + 40'd4), 0, 0,4,0);
      // credit return with counter full
      add(0,0,0,0,0,1, 0, 0, 0, 0,                              0,0,0,0,0,0, 0, 0, 0,4,0);
      add(0,0,0,0,0,0, 0, 0, 0, 0,                              0,0,0,0,0,0, 0, 0, 0,4,1);
      add(0,0,0,0,0,0, 0, 0, 0, 0,                              0,0,0,0,0,0, 0, 0, 0,4,1);

      repeat (3) @(posedge clk);
      for (int i = 0; i < tv.size(); i++) begin
         tick();
         rst = 1'b0;
         req_vld = tv[i].vld; req_wr = tv[i].wr; req_sz16 = tv[i].sz16; req_byp = tv[i].byp;
         req_tag = tv[i].tag; req_pa = tv[i].pa; wr_data = tv[i].wd; wr_be = tv[i].wbe;
         oqdq = tv[i].oqdq; bqdq = tv[i].bqdq; inj = 1'b0;
         @(negedge clk);
         chk($sformatf("row%0d req_rdy", i),    128'(req_rdy),    128'(tv[i].e_rdy));
         chk($sformatf("row%0d wr_data_rd", i), 128'(wr_data_rd), 128'(tv[i].e_rd));
         chk($sformatf("row%0d hdr_vld", i),    128'(hdr_vld),    128'(tv[i].e_hdr));
         chk($sformatf("row%0d reqbypass", i),  128'(reqbypass),  128'(tv[i].e_byp));
         chk($sformatf("row%0d datareq", i),    128'(datareq),    128'(tv[i].e_dreq));
         chk($sformatf("row%0d datareq16", i),  128'(datareq16),  128'(tv[i].e_dreq16));
         chk($sformatf("row%0d data", i),       sii_data,         tv[i].e_data);
         chk($sformatf("row%0d be", i),         128'(sii_be),     128'(tv[i].e_be));
         chk($sformatf("row%0d parity", i),     128'(sii_parity), 128'(par(tv[i].e_data)));
         chk($sformatf("row%0d oq_cred", i),    128'(dut.oq_cred_reg), 128'(tv[i].e_oq));
         chk($sformatf("row%0d bq_cred", i),    128'(dut.bq_cred_reg), 128'(tv[i].e_bq));
         chk($sformatf("row%0d cred_err", i),   128'(cred_err),   128'(tv[i].e_err));
      end

      // reset in the middle of a 64B ordered write
      tick(); clr_in(); rst = 1'b1;
      tick();
      tick(); rst = 1'b0;
      req_vld = 1; req_wr = 1; req_tag = 16'h5555; req_pa = 40'h77;
      @(negedge clk);
      chk("rst_seq accept", 128'(req_rdy), 128'(1'b1));
      tick(); clr_in(); wr_data = dbeat(10); wr_be = 16'hFFFF;
      @(negedge clk);
      chk("rst_seq hdr", 128'(hdr_vld), 128'(1'b1));
      chk("rst_seq oq_dec", 128'(dut.oq_cred_reg), 128'(4'd3));
      tick(); wr_data = dbeat(11);
      @(negedge clk);
      chk("rst_seq beat0", sii_data, dbeat(10));
      tick(); wr_data = dbeat(12);
      @(negedge clk);
      chk("rst_seq beat1", sii_data, dbeat(11));
      tick(); wr_data = dbeat(13); rst = 1'b1;
      @(negedge clk);
      chk("rst_seq beat2", sii_data, dbeat(12));
      tick(); rst = 1'b0; clr_in();
      @(negedge clk);
      chk("rst_seq data0",   sii_data, 128'd0);
      chk("rst_seq be0",     128'(sii_be), 128'd0);
      chk("rst_seq par0",    128'(sii_parity), 128'd0);
      chk("rst_seq hdr0",    128'(hdr_vld), 128'd0);
      chk("rst_seq dreq0",   128'(datareq), 128'd0);
      chk("rst_seq oq4",     128'(dut.oq_cred_reg), 128'(4'd4));
      chk("rst_seq bq4",     128'(dut.bq_cred_reg), 128'(4'd4));
      chk("rst_seq err0",    128'(cred_err), 128'd0);
      chk("rst_seq no_rd_a", 128'(wr_data_rd), 128'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         @(negedge clk);
         chk($sformatf("rst_seq no_rd_%0d", k), 128'(wr_data_rd), 128'd0);
         chk($sformatf("rst_seq idle_data_%0d", k), sii_data, 128'd0);
      end

      // parity injection on a header; ignored when nothing is registered
      tick(); clr_in();
      req_vld = 1; req_tag = 16'h0001; req_pa = 40'h0; inj = 1;
      @(negedge clk);
      chk("par_seq accept", 128'(req_rdy), 128'(1'b1));
      tick(); clr_in(); inj = 1;
      @(negedge clk);
      chk("par_seq hdr", 128'(hdr_vld), 128'(1'b1));
`ifdef NIU_SII_PAR_INJ_EN
      chk("par_seq inj", 128'(sii_parity), 128'(8'h11));
`else
      chk("par_seq inj", 128'(sii_parity), 128'(8'h10));
`endif
      tick(); clr_in();
      @(negedge clk);
      chk("par_seq after", 128'(sii_parity), 128'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
